// File: rtl/uart_core.sv
// uart_core: parametrised full-duplex UART with a valid/ready transmitter,
// a synchronised receiver with false-start, parity and framing checks, and
// a first-word-fall-through RX FIFO that reports overruns.
module uart_core #(
    parameter int CLK_FREQ      = 50000000,
    parameter int BAUDRATE      = 115200,
    parameter int DATA_BITS     = 8,
    parameter int PARITY        = 0,
    parameter int STOP_BITS     = 1,
    parameter int RX_FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_overrun
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUDRATE;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
    localparam int IDX_W        = $clog2(DATA_BITS + 1);
    localparam int PTR_W        = $clog2(RX_FIFO_DEPTH);
    localparam int ENTRY_W      = DATA_BITS + 2;

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(CLKS_PER_BIT - 2);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
    localparam logic [PTR_W:0]   FIFO_FULL = (PTR_W + 1)'(RX_FIFO_DEPTH);
    localparam logic             STOP_IDX_LAST = 1'(STOP_BITS - 1);
    localparam logic             ODD_PARITY    = (PARITY == 1);
    localparam logic             HAS_PARITY    = (PARITY != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               tx_state;
    logic [CNT_W-1:0]     tx_cnt;
    logic [IDX_W-1:0]     tx_idx;
    logic                 tx_stop;
    logic [DATA_BITS-1:0] tx_shift;
    logic                 tx_par;

    state_t               rx_state;
    logic                 rx_meta;
    logic                 rxs;
    logic                 rx_armed;
    logic [CNT_W-1:0]     rx_cnt;
    logic [IDX_W-1:0]     rx_idx;
    logic                 rx_stop;
    logic [DATA_BITS-1:0] rx_shift;
    logic                 rx_perr;
    logic                 rx_ferr;
    logic                 rx_push;

    logic [ENTRY_W-1:0]   fifo_mem [RX_FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [PTR_W:0]       count;
    logic                 fifo_full;
    logic                 do_push;
    logic                 do_pop;
    logic [ENTRY_W-1:0]   head;

    // Transmit FSM; the final stop bit hands back to IDLE one cycle early so a
    // waiting word starts its start bit right after the stop bit with no gap.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= S_IDLE;
            tx       <= 1'b1;
            tx_ready <= 1'b1;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_stop  <= 1'b0;
            tx_shift <= '0;
            tx_par   <= 1'b0;
        end else begin
            case (tx_state)
                S_IDLE: begin
                    if (tx_valid && tx_ready) begin
                        tx_shift <= tx_data;
                        tx_par   <= (^tx_data) ^ ODD_PARITY;
                        tx       <= 1'b0;
                        tx_ready <= 1'b0;
                        tx_cnt   <= '0;
                        tx_state <= S_START;
                    end
                end
                S_START: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt   <= '0;
                        tx       <= tx_shift[0];
                        tx_shift <= tx_shift >> 1;
                        tx_idx   <= '0;
                        tx_state <= S_DATA;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt <= '0;
                        if (tx_idx == IDX_LAST) begin
                            if (HAS_PARITY) begin
                                tx       <= tx_par;
                                tx_state <= S_PARITY;
                            end else begin
                                tx       <= 1'b1;
                                tx_stop  <= 1'b0;
                                tx_state <= S_STOP;
                            end
                        end else begin
                            tx       <= tx_shift[0];
                            tx_shift <= tx_shift >> 1;
                            tx_idx   <= tx_idx + 1'b1;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt   <= '0;
                        tx       <= 1'b1;
                        tx_stop  <= 1'b0;
                        tx_state <= S_STOP;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (tx_stop == STOP_IDX_LAST && tx_cnt == STOP_LAST) begin
                        tx_ready <= 1'b1;
                        tx_state <= S_IDLE;
                    end else if (tx_cnt == BIT_LAST) begin
                        tx_cnt  <= '0;
                        tx_stop <= 1'b1;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                default: begin
                    tx       <= 1'b1;
                    tx_ready <= 1'b1;
                    tx_state <= S_IDLE;
                end
            endcase
        end
    end

    // Two-flop synchroniser for the asynchronous serial input, idling high.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    // Receive FSM; a start is only accepted once the line has been high since
    // the last frame, so a held-low break yields a single errored frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state <= S_IDLE;
            rx_armed <= 1'b0;
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_stop  <= 1'b0;
            rx_shift <= '0;
            rx_perr  <= 1'b0;
            rx_ferr  <= 1'b0;
            rx_push  <= 1'b0;
        end else begin
            rx_push <= 1'b0;
            case (rx_state)
                S_IDLE: begin
                    if (rxs) begin
                        rx_armed <= 1'b1;
                    end else if (rx_armed) begin
                        rx_armed <= 1'b0;
                        rx_cnt   <= '0;
                        rx_state <= S_START;
                    end
                end
                S_START: begin
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt <= '0;
                        if (rxs) begin
                            rx_state <= S_IDLE;
                        end else begin
                            rx_idx   <= '0;
                            rx_perr  <= 1'b0;
                            rx_ferr  <= 1'b0;
                            rx_state <= S_DATA;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rxs, rx_shift[DATA_BITS-1:1]};
                        if (rx_idx == IDX_LAST) begin
                            rx_stop  <= 1'b0;
                            rx_state <= HAS_PARITY ? S_PARITY : S_STOP;
                        end else begin
                            rx_idx <= rx_idx + 1'b1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_perr  <= rxs != ((^rx_shift) ^ ODD_PARITY);
                        rx_stop  <= 1'b0;
                        rx_state <= S_STOP;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt <= '0;
                        if (!rxs) begin
                            rx_ferr <= 1'b1;
                        end
                        if (rx_stop == STOP_IDX_LAST) begin
                            rx_push  <= 1'b1;
                            rx_state <= S_IDLE;
                        end else begin
                            rx_stop <= 1'b1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                default: begin
                    rx_state <= S_IDLE;
                end
            endcase
        end
    end

    // FIFO push/pop decisions; a pop frees the slot a same-cycle push needs.
    always_comb begin
        fifo_full = (count == FIFO_FULL);
        do_pop    = (count != '0) && rx_ready;
        do_push   = rx_push && (!fifo_full || do_pop);
        head      = fifo_mem[rd_ptr];
    end

    // FIFO storage writes; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            fifo_mem[wr_ptr] <= {rx_shift, rx_perr, rx_ferr};
        end
    end

    // FIFO pointers, occupancy and the overrun pulse for dropped frames.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            rx_overrun <= 1'b0;
        end else begin
            rx_overrun <= rx_push && fifo_full && !do_pop;
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (!do_push && do_pop) begin
                count <= count - 1'b1;
            end
        end
    end

    assign rx_valid      = (count != '0);
    assign rx_data       = rx_valid ? head[ENTRY_W-1:2] : '0;
    assign rx_parity_err = rx_valid ? head[1] : 1'b0;
    assign rx_frame_err  = rx_valid ? head[0] : 1'b0;

endmodule

// File: tb/tb_uart_core.sv
// tb_uart_core: randomized self-checking bench for uart_core, using an 8N1
// instance and a 7-data-bit even-parity two-stop instance side by side.
`timescale 1ns/1ps
module tb_uart_core;

    localparam int CF    = 1000000;
    localparam int BR    = 100000;
    localparam int C     = CF / BR;
    localparam int A_DB  = 8;
    localparam int A_PAR = 0;
    localparam int A_SB  = 1;
    localparam int A_F   = C * (1 + A_DB + 0 + A_SB);
    localparam int B_DB  = 7;
    localparam int B_PAR = 2;
    localparam int B_SB  = 2;
    localparam int B_F   = C * (1 + B_DB + 1 + B_SB);

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic [7:0] a_tx_data = '0;
    logic       a_tx_valid = 1'b0;
    logic       a_tx_ready;
    logic       a_tx;
    logic       a_rx = 1'b1;
    logic [7:0] a_rx_data;
    logic       a_perr, a_ferr, a_rx_valid, a_ovr;
    logic       a_rx_ready = 1'b0;

    logic [6:0] b_tx_data = '0;
    logic       b_tx_valid = 1'b0;
    logic       b_tx_ready;
    logic       b_tx;
    logic       b_rx;
    logic       b_rx_drv = 1'b1;
    logic       b_loop = 1'b0;
    logic [6:0] b_rx_data;
    logic       b_perr, b_ferr, b_rx_valid, b_ovr;
    logic       b_rx_ready = 1'b0;

    int total = 0;
    int bad = 0;
    int a_ovr_cnt = 0;

    always #5 clk = ~clk;

    assign b_rx = b_loop ? b_tx : b_rx_drv;

    uart_core #(.CLK_FREQ(CF), .BAUDRATE(BR), .DATA_BITS(A_DB), .PARITY(A_PAR),
                .STOP_BITS(A_SB), .RX_FIFO_DEPTH(4)) u_a (
        .clk(clk), .rst(rst), .tx_data(a_tx_data), .tx_valid(a_tx_valid),
        .tx_ready(a_tx_ready), .tx(a_tx), .rx(a_rx), .rx_data(a_rx_data),
        .rx_parity_err(a_perr), .rx_frame_err(a_ferr), .rx_valid(a_rx_valid),
        .rx_ready(a_rx_ready), .rx_overrun(a_ovr));

    uart_core #(.CLK_FREQ(CF), .BAUDRATE(BR), .DATA_BITS(B_DB), .PARITY(B_PAR),
                .STOP_BITS(B_SB), .RX_FIFO_DEPTH(4)) u_b (
        .clk(clk), .rst(rst), .tx_data(b_tx_data), .tx_valid(b_tx_valid),
        .tx_ready(b_tx_ready), .tx(b_tx), .rx(b_rx), .rx_data(b_rx_data),
        .rx_parity_err(b_perr), .rx_frame_err(b_ferr), .rx_valid(b_rx_valid),
        .rx_ready(b_rx_ready), .rx_overrun(b_ovr));

    // Count overrun pulse cycles on instance A.
    always @(negedge clk) begin
        if (a_ovr) a_ovr_cnt <= a_ovr_cnt + 1;
    end

    // Parity bit: even = XOR of data bits, odd = its inverse.
    function automatic bit par_bit(input int data, input int db, input int par);
        int ones;
        ones = 0;
        for (int i = 0; i < db; i++) ones += (data >> i) & 1;
        if (par == 2) return bit'(ones % 2);
        return bit'(1 - (ones % 2));
    endfunction

    // Line level of bit position pos in a frame (0 = start bit).
    function automatic bit line_bit(input int data, input int db, input int par, input int pos);
        if (pos == 0) return 1'b0;
        if (pos <= db) return bit'((data >> (pos - 1)) & 1);
        if (par != 0 && pos == db + 1) return par_bit(data, db, par);
        return 1'b1;
    endfunction

    task automatic drive_frame(input int which, input int data, input bit bad_par, input bit bad_stop);
        int db, par, sb, nbits;
        bit v;
        db = (which == 0) ? A_DB : B_DB;
        par = (which == 0) ? A_PAR : B_PAR;
        sb = (which == 0) ? A_SB : B_SB;
        nbits = 1 + db + ((par != 0) ? 1 : 0) + sb;
        for (int pos = 0; pos < nbits; pos++) begin
            v = line_bit(data, db, par, pos);
            if (bad_par && par != 0 && pos == db + 1) v = ~v;
            if (bad_stop && pos == nbits - sb) v = 1'b0;
            if (which == 0) a_rx = v; else b_rx_drv = v;
            repeat (C) @(negedge clk);
        end
        if (which == 0) a_rx = 1'b1; else b_rx_drv = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (a_tx !== 1'b1) begin bad++; $display("[TB] FAIL reset_a_tx: got %0b want 1", a_tx); end
        total++; if (a_tx_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_a_tx_ready: got %0b want 1", a_tx_ready); end
        total++; if (a_rx_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_a_rx_valid: got %0b want 0", a_rx_valid); end
        total++; if (a_rx_data !== 8'h00) begin bad++; $display("[TB] FAIL reset_a_rx_data: got %h want 00", a_rx_data); end
        total++; if (a_perr !== 1'b0) begin bad++; $display("[TB] FAIL reset_a_perr: got %0b want 0", a_perr); end
        total++; if (a_ferr !== 1'b0) begin bad++; $display("[TB] FAIL reset_a_ferr: got %0b want 0", a_ferr); end
        total++; if (a_ovr !== 1'b0) begin bad++; $display("[TB] FAIL reset_a_ovr: got %0b want 0", a_ovr); end
        total++; if (b_tx !== 1'b1) begin bad++; $display("[TB] FAIL reset_b_tx: got %0b want 1", b_tx); end
        total++; if (b_tx_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_b_tx_ready: got %0b want 1", b_tx_ready); end
        total++; if (b_rx_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_b_rx_valid: got %0b want 0", b_rx_valid); end
        rst = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_tx_8n1();
        int errs, rdy_errs, first_j, n;
        bit exp;
        errs = 0; rdy_errs = 0; first_j = -1; n = 0;
        while (!a_tx_ready && n < 300) begin @(negedge clk); n++; end
        a_tx_data = 8'hA5;
        a_tx_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a_tx_data = 8'h3C;
        for (int j = 0; j < 2 * A_F; j++) begin
            exp = (j < A_F) ? line_bit(8'hA5, A_DB, A_PAR, j / C) : line_bit(8'h3C, A_DB, A_PAR, (j - A_F) / C);
            if (a_tx !== exp) begin errs++; if (first_j < 0) first_j = j; end
            if ((j < A_F - 1 || (j >= A_F && j < 2 * A_F - 1)) && a_tx_ready !== 1'b0) rdy_errs++;
            if (j == A_F) a_tx_valid = 1'b0;
            @(negedge clk);
        end
        a_tx_valid = 1'b0;
        total++; if (errs != 0) begin bad++; $display("[TB] FAIL tx_a5_3c_line: %0d wrong cycles, first at %0d, want 0 wrong", errs, first_j); end
        total++; if (rdy_errs != 0) begin bad++; $display("[TB] FAIL tx_ready_busy: %0d cycles high while busy, want 0", rdy_errs); end
        total++; if (a_tx_ready !== 1'b1) begin bad++; $display("[TB] FAIL tx_ready_after: got %0b want 1", a_tx_ready); end
        total++; if (a_tx !== 1'b1) begin bad++; $display("[TB] FAIL tx_idle_after: got %0b want 1", a_tx); end
    endtask

    task automatic test_tx_random();
        logic [7:0] d;
        int errs, n;
        for (int k = 0; k < 4; k++) begin
            d = 8'($urandom_range(0, 255));
            errs = 0; n = 0;
            repeat ($urandom_range(0, 5)) @(negedge clk);
            while (!a_tx_ready && n < 300) begin @(negedge clk); n++; end
            a_tx_data = d;
            a_tx_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            a_tx_valid = 1'b0;
            a_tx_data = ~d;
            for (int j = 0; j < A_F; j++) begin
                if (a_tx !== line_bit(int'(d), A_DB, A_PAR, j / C)) errs++;
                @(negedge clk);
            end
            total++; if (errs != 0) begin bad++; $display("[TB] FAIL tx_rand_line: data %h had %0d wrong cycles, want 0", d, errs); end
            total++; if (a_tx_ready !== 1'b1) begin bad++; $display("[TB] FAIL tx_rand_ready: got %0b want 1", a_tx_ready); end
        end
    endtask

    task automatic test_loopback();
        logic [6:0] w;
        int errs, n;
        b_loop = 1'b1;
        for (int k = 0; k < 4; k++) begin
            w = (k == 0) ? 7'h07 : 7'($urandom_range(0, 127));
            errs = 0; n = 0;
            while (!b_tx_ready && n < 300) begin @(negedge clk); n++; end
            b_tx_data = w;
            b_tx_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            b_tx_valid = 1'b0;
            for (int j = 0; j < B_F; j++) begin
                if (b_tx !== line_bit(int'(w), B_DB, B_PAR, j / C)) errs++;
                if (k == 0 && j == 8 * C + C / 2) begin
                    total++; if (b_tx !== 1'b1) begin bad++; $display("[TB] FAIL loop_parity_bit: got %0b want 1", b_tx); end
                end
                @(negedge clk);
            end
            total++; if (errs != 0) begin bad++; $display("[TB] FAIL loop_line: data %h had %0d wrong cycles, want 0", w, errs); end
            n = 0;
            while (!b_rx_valid && n < 40) begin @(negedge clk); n++; end
            total++; if (b_rx_valid !== 1'b1) begin bad++; $display("[TB] FAIL loop_rx_valid: got %0b want 1", b_rx_valid); end
            total++; if (b_rx_data !== w) begin bad++; $display("[TB] FAIL loop_rx_data: got %h want %h", b_rx_data, w); end
            total++; if ({b_perr, b_ferr} !== 2'b00) begin bad++; $display("[TB] FAIL loop_flags: got %b want 00", {b_perr, b_ferr}); end
            b_rx_ready = 1'b1;
            @(negedge clk);
            b_rx_ready = 1'b0;
            total++; if (b_rx_valid !== 1'b0) begin bad++; $display("[TB] FAIL loop_pop: rx_valid got %0b want 0", b_rx_valid); end
        end
        b_loop = 1'b0;
        repeat (C) @(negedge clk);
    endtask

    task automatic test_parity_err();
        logic [6:0] w;
        int n;
        for (int k = 0; k < 2; k++) begin
            w = 7'($urandom_range(0, 127));
            drive_frame(1, int'(w), k == 0, k == 1);
            repeat (C) @(negedge clk);
            n = 0;
            while (!b_rx_valid && n < 40) begin @(negedge clk); n++; end
            total++; if (b_rx_data !== w || b_rx_valid !== 1'b1) begin bad++; $display("[TB] FAIL err_data: got %h valid %0b want %h valid 1", b_rx_data, b_rx_valid, w); end
            total++; if ({b_perr, b_ferr} !== ((k == 0) ? 2'b10 : 2'b01)) begin bad++; $display("[TB] FAIL err_flags case %0d: got %b want %b", k, {b_perr, b_ferr}, (k == 0) ? 2'b10 : 2'b01); end
            b_rx_ready = 1'b1;
            @(negedge clk);
            b_rx_ready = 1'b0;
        end
    endtask

    task automatic test_break();
        logic [7:0] w;
        int n;
        a_rx_ready = 1'b0;
        a_rx = 1'b0;
        repeat (300) @(negedge clk);
        a_rx = 1'b1;
        repeat (30) @(negedge clk);
        total++; if (a_rx_valid !== 1'b1 || a_rx_data !== 8'h00) begin bad++; $display("[TB] FAIL break_frame: valid %0b data %h want valid 1 data 00", a_rx_valid, a_rx_data); end
        total++; if ({a_perr, a_ferr} !== 2'b01) begin bad++; $display("[TB] FAIL break_flags: got %b want 01", {a_perr, a_ferr}); end
        a_rx_ready = 1'b1;
        @(negedge clk);
        a_rx_ready = 1'b0;
        total++; if (a_rx_valid !== 1'b0) begin bad++; $display("[TB] FAIL break_single: rx_valid got %0b want 0", a_rx_valid); end
        w = 8'($urandom_range(0, 255));
        drive_frame(0, int'(w), 1'b0, 1'b0);
        repeat (C) @(negedge clk);
        n = 0;
        while (!a_rx_valid && n < 40) begin @(negedge clk); n++; end
        total++; if (a_rx_data !== w || {a_perr, a_ferr} !== 2'b00) begin bad++; $display("[TB] FAIL break_recover: got %h flags %b want %h flags 00", a_rx_data, {a_perr, a_ferr}, w); end
        a_rx_ready = 1'b1;
        @(negedge clk);
        a_rx_ready = 1'b0;
    endtask

    task automatic test_glitch();
        int seen;
        seen = 0;
        a_rx = 1'b0;
        repeat (3) @(negedge clk);
        a_rx = 1'b1;
        for (int j = 0; j < 4 * C; j++) begin
            if (a_rx_valid !== 1'b0) seen++;
            @(negedge clk);
        end
        total++; if (seen != 0) begin bad++; $display("[TB] FAIL glitch: rx_valid high %0d cycles, want 0", seen); end
    endtask

    task automatic test_overrun();
        int base, after4;
        base = a_ovr_cnt;
        after4 = 0;
        a_rx_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            drive_frame(0, 8'h11 * k, 1'b0, 1'b0);
            repeat (C) @(negedge clk);
            if (k == 4) after4 = a_ovr_cnt - base;
        end
        total++; if (after4 != 0) begin bad++; $display("[TB] FAIL ovr_early: pulses %0d want 0", after4); end
        total++; if (a_ovr_cnt - base != 1) begin bad++; $display("[TB] FAIL ovr_count: pulses %0d want 1", a_ovr_cnt - base); end
        for (int k = 1; k <= 4; k++) begin
            total++; if (a_rx_valid !== 1'b1 || a_rx_data !== 8'(8'h11 * k)) begin bad++; $display("[TB] FAIL ovr_read %0d: got %h valid %0b want %h", k, a_rx_data, a_rx_valid, 8'(8'h11 * k)); end
            a_rx_ready = 1'b1;
            @(negedge clk);
            a_rx_ready = 1'b0;
        end
        total++; if (a_rx_valid !== 1'b0) begin bad++; $display("[TB] FAIL ovr_empty: rx_valid got %0b want 0", a_rx_valid); end
    endtask

    task automatic test_rx_random();
        logic [7:0] q[$];
        logic [7:0] w, exp;
        int n;
        for (int round = 0; round < 2; round++) begin
            n = $urandom_range(1, 4);
            for (int k = 0; k < n; k++) begin
                w = 8'($urandom_range(0, 255));
                q.push_back(w);
                drive_frame(0, int'(w), 1'b0, 1'b0);
                repeat ($urandom_range(1, 2 * C)) @(negedge clk);
            end
            repeat (C) @(negedge clk);
            while (q.size() > 0) begin
                exp = q.pop_front();
                total++; if (a_rx_valid !== 1'b1 || a_rx_data !== exp) begin bad++; $display("[TB] FAIL rx_rand: got %h valid %0b want %h", a_rx_data, a_rx_valid, exp); end
                a_rx_ready = 1'b1;
                @(negedge clk);
                a_rx_ready = 1'b0;
            end
            total++; if (a_rx_valid !== 1'b0) begin bad++; $display("[TB] FAIL rx_rand_empty: rx_valid got %0b want 0", a_rx_valid); end
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] w;
        int seen, n;
        w = 8'($urandom_range(0, 255));
        seen = 0; n = 0;
        while (!a_tx_ready && n < 300) begin @(negedge clk); n++; end
        a_tx_data = 8'($urandom_range(0, 255));
        a_tx_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a_tx_valid = 1'b0;
        for (int j = 0; j < 4 * C; j++) begin
            a_rx = line_bit(int'(w), A_DB, A_PAR, j / C);
            @(negedge clk);
        end
        rst = 1'b1;
        a_rx = 1'b1;
        @(negedge clk);
        total++; if (a_tx !== 1'b1 || a_tx_ready !== 1'b1) begin bad++; $display("[TB] FAIL mid_reset_tx: tx %0b ready %0b want 1 1", a_tx, a_tx_ready); end
        rst = 1'b0;
        for (int j = 0; j < 2 * A_F; j++) begin
            if (a_rx_valid !== 1'b0) seen++;
            @(negedge clk);
        end
        total++; if (seen != 0) begin bad++; $display("[TB] FAIL mid_reset_push: rx_valid high %0d cycles, want 0", seen); end
        w = 8'($urandom_range(0, 255));
        drive_frame(0, int'(w), 1'b0, 1'b0);
        repeat (C) @(negedge clk);
        n = 0;
        while (!a_rx_valid && n < 40) begin @(negedge clk); n++; end
        total++; if (a_rx_data !== w || {a_perr, a_ferr} !== 2'b00 || a_rx_valid !== 1'b1) begin bad++; $display("[TB] FAIL mid_reset_next: got %h flags %b valid %0b want %h 00 1", a_rx_data, {a_perr, a_ferr}, a_rx_valid, w); end
        a_rx_ready = 1'b1;
        @(negedge clk);
        a_rx_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_tx_8n1();
        test_tx_random();
        test_loopback();
        test_parity_err();
        test_break();
        test_glitch();
        test_overrun();
        test_rx_random();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        bad++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
